// File: rtl/des_decrypt_key_sched.sv
// DES decryption key scheduler: latches PC-1(KEY) on START and hands out K16..K1,
// one subkey per SUBKEY_VALID/SUBKEY_ACK handshake, by rotating C/D right.
module des_decrypt_key_sched (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [63:0] KEY,
    output logic [47:0] SUBKEY,
    output logic        SUBKEY_VALID,
    input  logic        SUBKEY_ACK,
    output logic [3:0]  ROUND,
    output logic        BUSY,
    output logic        DONE
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Tables use FIPS bit numbering: bit 1 is the MSB of the vector.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[55 - i] = k[64 - PC1_TAB[i]];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[47 - i] = cd[56 - PC2_TAB[i]];
        end
        return r;
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic by_one);
        return by_one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    logic [0:0]  state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        single_shift;

    // Moving to decrypt index 1, 8 and 15 undoes a 1-bit encryption shift; all others are 2.
    assign single_shift = (cnt_q == 4'd0) || (cnt_q == 4'd7) || (cnt_q == 4'd14);

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    {c_d, d_d} = pc1(KEY);
                    cnt_d      = 4'd0;
                    state_d    = ST_RUN;
                end
            end
            default: begin
                if (SUBKEY_ACK) begin
                    if (cnt_q == 4'd15) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        c_d   = rotr(c_q, single_shift);
                        d_d   = rotr(d_q, single_shift);
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign SUBKEY       = pc2({c_q, d_q});
    assign SUBKEY_VALID = (state_q == ST_RUN);
    assign BUSY         = (state_q == ST_RUN);
    assign ROUND        = cnt_q;
    assign DONE         = done_q;

endmodule

// File: tb/tb_des_decrypt_key_sched.sv
// Bench for des_decrypt_key_sched: expected subkeys are queued at START and a
// negedge monitor pops/compares them on every handshake.
module tb_des_decrypt_key_sched;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [63:0] KEY;
    logic [47:0] SUBKEY;
    logic        SUBKEY_VALID;
    logic        SUBKEY_ACK;
    logic [3:0]  ROUND;
    logic        BUSY;
    logic        DONE;

    int n_cmp = 0;
    int n_bad = 0;

    logic [51:0] sb [$];

    localparam logic [63:0] K_STD = 64'h133457799BBCDFF1;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    des_decrypt_key_sched dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .START        (START),
        .KEY          (KEY),
        .SUBKEY       (SUBKEY),
        .SUBKEY_VALID (SUBKEY_VALID),
        .SUBKEY_ACK   (SUBKEY_ACK),
        .ROUND        (ROUND),
        .BUSY         (BUSY),
        .DONE         (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Forward encryption schedule with left shifts on bit arrays, queued in reverse.
    task automatic push_model(input logic [63:0] k);
        bit kb [1:64];
        bit c [1:28];
        bit d [1:28];
        bit cd [1:56];
        bit t;
        logic [47:0] ks [1:16];
        for (int i = 1; i <= 64; i++) kb[i] = k[64 - i];
        for (int i = 1; i <= 28; i++) begin
            c[i] = kb[PC1[i - 1]];
            d[i] = kb[PC1[i + 27]];
        end
        for (int r = 1; r <= 16; r++) begin
            for (int s = 0; s < SHIFTS[r - 1]; s++) begin
                t = c[1];
                for (int j = 1; j < 28; j++) c[j] = c[j + 1];
                c[28] = t;
                t = d[1];
                for (int j = 1; j < 28; j++) d[j] = d[j + 1];
                d[28] = t;
            end
            for (int i = 1; i <= 28; i++) begin
                cd[i]      = c[i];
                cd[i + 28] = d[i];
            end
            for (int i = 0; i < 48; i++) ks[r][47 - i] = cd[PC2[i]];
        end
        for (int r = 16; r >= 1; r--) sb.push_back({4'(16 - r), ks[r]});
    endtask

    task automatic push_const(input logic [47:0] v);
        for (int r = 0; r < 16; r++) sb.push_back({4'(r), v});
    endtask

    // Called just after a clock edge; returns one cycle after the START edge.
    task automatic start_key(input logic [63:0] k, input bit use_model);
        if (use_model) push_model(k);
        KEY   = k;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        KEY   = {$urandom(), $urandom()};
        check("start_valid", SUBKEY_VALID, 1);
        check("start_round", ROUND, 0);
        check("start_busy", BUSY, 1);
    endtask

    // mode 0: ACK held high; mode 1: random ACK with stalls of 3..5 cycles.
    task automatic run(input int mode, input bit golden, input bit inject, input logic [63:0] inj_key);
        int edges, ack_cycles, stall;
        bit injected, got_done;
        edges = 0; ack_cycles = 0; stall = 0; injected = 0; got_done = 0;
        while (!got_done && edges < 400) begin
            START = 1'b0;
            if (inject && !injected && SUBKEY_VALID && ROUND == 4'd5) begin
                START    = 1'b1;
                KEY      = inj_key;
                injected = 1'b1;
            end
            if (mode == 0) SUBKEY_ACK = 1'b1;
            else if (stall > 0) begin
                SUBKEY_ACK = 1'b0;
                stall--;
            end else if ($urandom_range(2) == 0) begin
                SUBKEY_ACK = 1'b0;
                stall = $urandom_range(4, 2);
            end else SUBKEY_ACK = 1'b1;
            if (golden && SUBKEY_VALID && SUBKEY_ACK) begin
                case (ROUND)
                    4'd0:  check("golden_r0", SUBKEY, 48'hCB3D8B0E17F5);
                    4'd1:  check("golden_r1", SUBKEY, 48'hBF918D3D3F0A);
                    4'd14: check("golden_r14", SUBKEY, 48'h79AED9DBC9E5);
                    4'd15: check("golden_r15", SUBKEY, 48'h1B02EFFC7072);
                    default: ;
                endcase
            end
            if (SUBKEY_ACK && SUBKEY_VALID) ack_cycles++;
            @(posedge CLK); #1;
            edges++;
            got_done = DONE;
        end
        START      = 1'b0;
        SUBKEY_ACK = 1'b0;
        check("done_seen", got_done, 1);
        check("acks_before_done", ack_cycles, 16);
        if (mode == 0) check("done_latency", edges, 16);
        check("valid_on_done", SUBKEY_VALID, 0);
        check("busy_on_done", BUSY, 0);
    endtask

    // Monitor: pops on each handshake, checks hold-stability during stalls and the DONE count.
    int          hs = 0;
    bit          have_prev = 0;
    logic [47:0] prev_sk;
    logic [3:0]  prev_rnd;
    logic [51:0] exp_e;

    always @(negedge CLK) begin
        if (RESET) begin
            hs = 0;
            have_prev = 0;
        end else begin
            if (SUBKEY_VALID) begin
                if (have_prev) begin
                    check("stall_subkey_stable", SUBKEY, prev_sk);
                    check("stall_round_stable", ROUND, prev_rnd);
                end
                if (SUBKEY_ACK) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_subkey: got round %0d subkey %h required none", ROUND, SUBKEY);
                    end else begin
                        exp_e = sb.pop_front();
                        check("round", ROUND, exp_e[51:48]);
                        check("subkey", SUBKEY, exp_e[47:0]);
                    end
                    hs++;
                    have_prev = 0;
                end else begin
                    have_prev = 1;
                    prev_sk   = SUBKEY;
                    prev_rnd  = ROUND;
                end
            end else have_prev = 0;
            if (DONE) begin
                check("handshakes_at_done", hs, 16);
                hs = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n_done;
        RESET = 1'b1; START = 1'b0; SUBKEY_ACK = 1'b0; KEY = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_valid", SUBKEY_VALID, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_round", ROUND, 0);
        check("rst_subkey", SUBKEY, 0);
        RESET = 1'b0;
        @(posedge CLK); #1;

        // Reference key, ACK held, golden checks and DONE timing.
        start_key(K_STD, 1);
        run(0, 1, 0, '0);
        @(posedge CLK); #1;
        check("done_cleared", DONE, 0);
        SUBKEY_ACK = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("ack_ignored_idle", SUBKEY_VALID, 0);
        SUBKEY_ACK = 1'b0;

        // Same key with random stalls.
        start_key(K_STD, 1);
        run(1, 1, 0, '0);

        // All-zero and all-one keys with hand-known subkeys.
        push_const(48'h0);
        start_key(64'h0, 0);
        run(0, 0, 0, '0);
        push_const(48'hFFFFFFFFFFFF);
        start_key(64'hFFFFFFFFFFFFFFFF, 0);
        run(1, 0, 0, '0);

        // Random keys, each started on the previous DONE cycle.
        for (int i = 0; i < 100; i++) begin
            start_key({$urandom(), $urandom()}, 1);
            run((i % 4 == 0) ? 1 : 0, 0, 0, '0);
        end

        // START with a new key at ROUND 5 must be ignored.
        start_key(64'h0E329232EA6D0D73, 1);
        run(0, 0, 1, 64'hA5A5A5A55A5A5A5A);

        // Parity bits flipped: same subkeys as the reference key.
        push_model(K_STD);
        start_key(K_STD ^ 64'h0101010101010101, 0);
        run(1, 1, 0, '0);

        // Reset at ROUND 7.
        @(posedge CLK); #1;
        start_key(64'h3B3898371520F75E, 1);
        for (int e = 0; e < 40 && !(SUBKEY_VALID && ROUND == 4'd7); e++) begin
            SUBKEY_ACK = 1'b1;
            @(posedge CLK); #1;
        end
        check("reached_round7", ROUND, 7);
        SUBKEY_ACK = 1'b0;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        check("midrst_valid", SUBKEY_VALID, 0);
        check("midrst_busy", BUSY, 0);
        check("midrst_done", DONE, 0);
        check("midrst_round", ROUND, 0);
        check("midrst_subkey", SUBKEY, 0);
        check("midrst_pending", sb.size(), 9);
        sb.delete();
        n_done = 0;
        repeat (4) begin
            @(posedge CLK); #1;
            if (DONE) n_done++;
        end
        check("midrst_no_done", n_done, 0);
        start_key(64'h3B3898371520F75E, 1);
        run(0, 0, 0, '0);

        repeat (3) @(posedge CLK);
        #1;
        check("queue_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
